// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: parametrised, pipelined carry-lookahead adder/subtractor.
// Supports ADD, ADC, SUB and RSB, with carry-out, signed overflow and a
// valid/ready handshake. The carry chain is cut at slice boundaries, and each
// stage resolves WIDTH/STAGES bits.
// Optional build macro: CLA_PIPE_SAT_EN enables a signed saturating result.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SW = WIDTH / STAGES;  // bits resolved per stage
  localparam int NG = SW / GROUP;      // lookahead groups per slice

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_RSB = 2'b11;

  // Adds one slice with GROUP-bit CLA cells and a second lookahead level across
  // the group P/G terms. The result is packed as {carry out, carry into the
  // slice MSB, sum}.
  function automatic logic [SW+1:0] slice_add(input logic [SW-1:0] x,
                                               input logic [SW-1:0] y,
                                               input logic          cin);
    logic [SW-1:0] g, p, s;
    logic [SW:0]   c;
    logic [NG:0]   cg;
    logic          gg, pg;
    g     = x & y;
    p     = x ^ y;
    c     = '0;
    cg    = '0;
    cg[0] = cin;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      pg = 1'b1;
      for (int b = 0; b < GROUP; b++) begin
        gg = g[j*GROUP+b] | (p[j*GROUP+b] & gg);
        pg = pg & p[j*GROUP+b];
      end
      cg[j+1] = gg | (pg & cg[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c[j*GROUP] = cg[j];
      for (int b = 0; b < GROUP - 1; b++) begin
        c[j*GROUP+b+1] = g[j*GROUP+b] | (p[j*GROUP+b] & c[j*GROUP+b]);
      end
    end
    c[SW] = cg[NG];
    s     = p ^ c[SW-1:0];
    return {c[SW], c[SW-1], s};
  endfunction

`ifdef CLA_PIPE_SAT_EN
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Clamps to the signed extreme on overflow. The sign of the true result
  // follows the operand MSBs, because overflow only happens when they match.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] sum,
                                               input logic             ovf,
                                               input logic             xm,
                                               input logic             ym);
    logic [WIDTH-1:0] r;
    r = sum;
    if (ovf) r = (!xm && !ym) ? SAT_MAX : SAT_MIN;
    return r;
  endfunction
`endif

  logic [WIDTH-1:0] x0, y0;
  logic             c0;

  logic [WIDTH-1:0] x_in   [STAGES];
  logic [WIDTH-1:0] y_in   [STAGES];
  logic [WIDTH-1:0] sum_in [STAGES];
  logic             c_in   [STAGES];
  logic             vld_in [STAGES];

  logic [WIDTH-1:0] x_p    [STAGES];
  logic [WIDTH-1:0] y_p    [STAGES];
  logic [WIDTH-1:0] sum_p  [STAGES];
  logic             c_p    [STAGES];
  logic             ovf_p  [STAGES];
  logic             vld_p  [STAGES];
  logic [STAGES:0]  ready;

  // Operand preparation: map each mode onto x + y + c0.
  always_comb begin
    x0 = in_a;
    y0 = in_b;
    c0 = 1'b0;
    case (in_op)
      OP_ADD: begin x0 = in_a; y0 = in_b;  c0 = 1'b0;   end
      OP_ADC: begin x0 = in_a; y0 = in_b;  c0 = in_cin; end
      OP_SUB: begin x0 = in_a; y0 = ~in_b; c0 = 1'b1;   end
      OP_RSB: begin x0 = in_b; y0 = ~in_a; c0 = 1'b1;   end
      default: ;
    endcase
  end

  assign ready[STAGES] = out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [SW+1:0]    res;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] sum_fin;
    logic             ovf_nxt;
    logic [WIDTH-1:0] x_r, y_r, sum_r;
    logic             c_r, ovf_r, vld_r;

    // ---- stage s boundary: stage 0 sources prepped operands, later stages
    // source the previous stage's registers ----
    if (s == 0) begin : g_src0
      assign x_in[s]   = x0;
      assign y_in[s]   = y0;
      assign c_in[s]   = c0;
      assign sum_in[s] = '0;
      assign vld_in[s] = in_valid;
    end else begin : g_srcn
      assign x_in[s]   = x_p[s-1];
      assign y_in[s]   = y_p[s-1];
      assign c_in[s]   = c_p[s-1];
      assign sum_in[s] = sum_p[s-1];
      assign vld_in[s] = vld_p[s-1];
    end

    assign res     = slice_add(x_in[s][s*SW +: SW], y_in[s][s*SW +: SW], c_in[s]);
    assign ovf_nxt = res[SW+1] ^ res[SW];

    // Merge this stage's slice into the sum carried forward from earlier stages.
    always_comb begin
      sum_nxt = sum_in[s];
      sum_nxt[s*SW +: SW] = res[SW-1:0];
    end

    if (s == STAGES - 1) begin : g_fin
`ifdef CLA_PIPE_SAT_EN
      assign sum_fin = sat_sum(sum_nxt, ovf_nxt, x_in[s][WIDTH-1], y_in[s][WIDTH-1]);
`else
      assign sum_fin = sum_nxt;
`endif
    end else begin : g_mid
      assign sum_fin = sum_nxt;
    end

    assign ready[s] = !vld_r | ready[s+1];

    // Stage register: a new op loads when this stage drains or is empty, and
    // the register holds its contents while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_r <= 1'b0;
        x_r   <= '0;
        y_r   <= '0;
        sum_r <= '0;
        c_r   <= 1'b0;
        ovf_r <= 1'b0;
      end else if (ready[s]) begin
        vld_r <= vld_in[s];
        if (vld_in[s]) begin
          x_r   <= x_in[s];
          y_r   <= y_in[s];
          sum_r <= sum_fin;
          c_r   <= res[SW+1];
          ovf_r <= ovf_nxt;
        end
      end
    end

    assign x_p[s]   = x_r;
    assign y_p[s]   = y_r;
    assign sum_p[s] = sum_r;
    assign c_p[s]   = c_r;
    assign ovf_p[s] = ovf_r;
    assign vld_p[s] = vld_r;
  end

  assign in_ready  = ready[0];
  assign out_valid = vld_p[STAGES-1];
  assign out_sum   = sum_p[STAGES-1];
  assign out_cout  = c_p[STAGES-1];
  assign out_ovf   = ovf_p[STAGES-1];

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 16-bit combinational CLA used in the multiplier datapath.
- Adder width and pipeline depth are parameters. The carry chain is cut at slice boundaries, so one operation is accepted per cycle at higher clock rates.
- Adds add/add-with-carry/subtract/reverse-subtract modes, carry-out, signed overflow and a valid/ready handshake with backpressure.
- Sits between the ALU operand registers and the result mux, and replaces the final adder in the multiplier.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of GROUP*STAGES.
- GROUP, 4, bits per lookahead group (4-bit CLA cell with group P/G).
- STAGES, 2, pipeline stages; each stage resolves WIDTH/STAGES bits of the carry chain; range 1..WIDTH/GROUP.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in, used by ADC only.
- in_op  in  2  00 ADD A+B, 01 ADC A+B+cin, 10 SUB A-B, 11 RSB B-A.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB; for SUB/RSB, 1 = no borrow.
- out_ovf  out  1  signed two's-complement overflow.

Behaviour:
- Operand prep, in stage 0 input logic:
  - ADD: x=A, y=B, c0=0.
  - ADC: x=A, y=B, c0=in_cin.
  - SUB: x=A, y=~B, c0=1.
  - RSB: x=B, y=~A, c0=1.
- Slicing: slice k = bits [(k+1)*W/STAGES-1 : k*W/STAGES].
  - Stage k adds slice k of x,y using CLA groups of GROUP bits plus a two-level lookahead across groups within the slice.
  - Stage k's carry-in is the registered carry from stage k-1 (c0 for k=0).
  - Unprocessed upper operand slices and completed lower sum slices are carried forward in per-stage registers.
- Latency: exactly STAGES cycles from accepted input to out_valid, with no stalls. Throughput is 1 op/cycle.
- Handshake:
  - Transfer on in_valid&in_ready, and on out_valid&out_ready.
  - Stage s holds valid_s; ready_s = !valid_s | ready_{s+1}, with ready_STAGES = out_ready; in_ready = ready_0.
  - A stalled stage holds all its data unchanged. Simultaneous drain and fill of a stage in the same cycle is allowed (no bubble).
  - out_sum/out_cout/out_ovf remain stable while out_valid & !out_ready.
  - Inputs are ignored when in_valid=0. in_a/in_b/in_op/in_cin are don't-care when not transferring.
- Overflow: out_ovf = carry into MSB XOR carry out of MSB, computed in the final stage.
- Wrap-around: sum is modulo 2^WIDTH. Carry beyond the MSB appears only on out_cout.
- Reset (async assert, sync-safe deassert externally):
  - All valid_s=0, data registers 0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight results; nothing is emitted afterwards for them.
- STAGES=1: a single registered stage, latency 1, whole-width lookahead.

Optional Feature:
- CLA_PIPE_SAT_EN defined:
  - Signed saturating result. When out_ovf=1, out_sum = 0x7F..F if the true result is positive (MSB of x and y both 0), else 0x80..0.
  - out_ovf still reports the overflow; out_cout is unchanged.
  - Applied in the final stage, no added latency.
- Undefined: wrapping result only, no saturation logic.

Test Plan (WIDTH=32, GROUP=4, STAGES=2 unless noted):
- ADD 0xFFFF_FFFF + 0x0000_0001, continuous out_ready -> out_valid exactly 2 cycles after accept; sum=0x0000_0000, cout=1, ovf=0 (carry ripples across the stage boundary).
- ADC 0x0000_FFFF + 0 with cin=1 -> 0x0001_0000, cout=0. SUB 5-7 -> 0xFFFF_FFFE, cout=0. RSB with A=5, B=7 -> 0x0000_0002, cout=1.
- ADD 0x7FFF_FFFF + 1 -> sum 0x8000_0000, ovf=1. With CLA_PIPE_SAT_EN: sum 0x7FFF_FFFF, ovf=1. SUB 0x8000_0000 - 1 with SAT -> 0x8000_0000, ovf=1.
- Backpressure:
  - Stream 6 back-to-back ops with out_ready low for cycles 3-6: in_ready deasserts once both stages are full.
  - No op is lost or duplicated; results emerge in order with outputs stable while stalled.
  - After release, output returns to 1 result/cycle.
- Assert rst_n low with 2 ops in flight -> out_valid=0 and all outputs 0 immediately (asynchronous). After release, in_ready=1 and the in-flight ops never appear.
- Random 10k ops, all modes, random valid/ready, STAGES in {1,2,4,8} -> results match a reference model ((x+y+c0) mod 2^32, cout, ovf) with latency STAGES when unstalled.
